// File: rtl/spi_txn_arbiter_pkg.sv
// spi_arb_pkg
// Shared definitions for the SPI transaction arbiter slice.
//   arb_state_t      : sequencer states (IDLE, ARB, LAUNCH, WAIT, RESP)
//   DEF_NUM_REQ      : default number of requesters
//   DEF_DATA_W       : default SPI word width
//   DEF_TIMEOUT_CYC  : default WAIT-state cycle budget before abort
package spi_arb_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_TIMEOUT_CYC = 400;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/spi_txn_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority picker. Searches req starting at
// rr_ptr and wrapping modulo NUM_REQ; reports the first asserted request.
// Ports:
//   req     in  NUM_REQ  request levels
//   rr_ptr  in  IDX_W    index with highest priority this round
//   onehot  out NUM_REQ  one-hot winner (zero when no request)
//   idx     out IDX_W    winner index (zero when no request)
//   any     out 1        at least one request asserted
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Walk the requesters in priority order; the first hit wins and later
  // hits are masked by 'any'. Positions past the top wrap back to zero.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int               pos;
      logic [IDX_W-1:0] p;
      pos = int'(rr_ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      p = IDX_W'(pos);
      if (!any && req[p]) begin
        any       = 1'b1;
        idx       = p;
        onehot[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
// Round-robin sequencer sharing one SPI master between NUM_REQ clients.
// A winner's TX word is latched, one SPI transaction is launched, and the
// received word (or a timeout error) is returned to that winner.
// Ports:
//   clk        in  1               system clock, rising edge
//   reset      in  1               synchronous active-low reset
//   req        in  NUM_REQ         per-requester request level
//   req_data   in  NUM_REQ*DATA_W  packed TX words, requester i at [i*DATA_W +: DATA_W]
//   gnt        out NUM_REQ         one-hot grant, ARB exit until RESP exit
//   rsp_valid  out NUM_REQ         one-cycle response pulse to the owner
//   rsp_data   out DATA_W          received word (zero on timeout)
//   rsp_err    out 1               timeout flag, qualified by rsp_valid
//   m_start    out 1               one-cycle start pulse to the SPI master
//   m_datain   out DATA_W          TX word presented to the master
//   m_busy     in  1               master activity (informational only)
//   m_done     in  1               master completion pulse
//   m_rdata    in  DATA_W          master received word, valid with m_done
//   busy       out 1               sequencer not idle
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      m_start,
  output logic [DATA_W-1:0]         m_datain,
  input  logic                      m_busy,
  input  logic                      m_done,
  input  logic [DATA_W-1:0]         m_rdata,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   winner;
  logic [CNT_W-1:0]   tmo_cnt;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   next_ptr;
  logic [DATA_W-1:0]  req_words [NUM_REQ];

  // The master's busy flag plays no part in sequencing; completion is
  // taken solely from m_done.
  logic unused_m_busy;
  assign unused_m_busy = m_busy;

  // Unpack the flat request word bus so the winner can be selected by index.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_words[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Priority moves to the requester just after the one served.
  assign next_ptr = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  // Sequencer. All outputs are registered and set on the edge that enters
  // the state they belong to, so m_start is high during LAUNCH and
  // rsp_valid is high during RESP. m_done is only looked at in WAIT, and
  // it takes precedence over a timeout in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      winner    <= '0;
      tmo_cnt   <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      m_start   <= 1'b0;
      m_datain  <= '0;
      busy      <= 1'b0;
    end else begin
      m_start   <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          if (pick_any) begin
            gnt      <= pick_onehot;
            winner   <= pick_idx;
            m_datain <= req_words[pick_idx];
            m_start  <= 1'b1;
            state    <= LAUNCH;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LAUNCH: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (m_done) begin
            rsp_data  <= m_rdata;
            rsp_err   <= 1'b0;
            rsp_valid <= gnt;
            state     <= RESP;
          end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= gnt;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          rr_ptr  <= next_ptr;
          gnt     <= '0;
          rsp_err <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
